// File: rtl/dsp_accumulator.sv
// Running-sum accumulator with sticky unsigned-carry and signed-overflow status.
// The result either wraps modulo 2^WIDTH or clamps at all-ones when SATURATE is set.
module dsp_accumulator #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0]   sum_s;
    logic             c_s;
    logic             ovf_s;
    logic [WIDTH-1:0] next_s;

    // Form the widened sum and decide the next accumulator value and flag events
    always_comb begin
        sum_s  = {1'b0, out} + {1'b0, in};
        c_s    = sum_s[WIDTH];
        // Signed overflow: like-signed operands producing a result of the other sign
        ovf_s  = (out[WIDTH-1] == in[WIDTH-1]) && (sum_s[WIDTH-1] != out[WIDTH-1]);
        if ((SATURATE != 1'b0) && c_s) begin
            next_s = {WIDTH{1'b1}};
        end else begin
            next_s = sum_s[WIDTH-1:0];
        end
    end

    // Accumulator and sticky flag registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            out   <= {WIDTH{1'b0}};
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            out   <= next_s;
            carry <= carry | c_s;
            ovf   <= ovf | ovf_s;
        end
    end

endmodule

// File: tb/tb_dsp_accumulator.sv
// Self-checking bench: wrap and saturating instances share stimulus; a reference
// model pushes expected results to a queue, popped and compared after each edge.
module tb_dsp_accumulator;

    logic        clk;
    logic        reset;
    logic [31:0] in;
    logic [31:0] out_w, out_s;
    logic        carry_w, carry_s, ovf_w, ovf_s;

    typedef struct {
        logic [31:0] out_w;
        logic        carry_w;
        logic        ovf_w;
        logic [31:0] out_s;
        logic        carry_s;
        logic        ovf_s;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_out[2];
    logic        m_c[2];
    logic        m_v[2];

    int n_cmp;
    int n_err;

    dsp_accumulator #(.WIDTH(32), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .in(in), .out(out_w), .carry(carry_w), .ovf(ovf_w)
    );

    dsp_accumulator #(.WIDTH(32), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .in(in), .out(out_s), .carry(carry_s), .ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: unsigned carry from a 64-bit sum, signed overflow from range check
    task automatic model_step(input logic r, input logic [31:0] v);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                m_out[k] = 32'd0;
                m_c[k]   = 1'b0;
                m_v[k]   = 1'b0;
            end else begin
                logic [63:0] us;
                longint      ss;
                logic        cy;
                logic        ov;
                us = {32'd0, m_out[k]} + {32'd0, v};
                ss = longint'($signed(m_out[k])) + longint'($signed(v));
                cy = (us > 64'h0000_0000_FFFF_FFFF);
                ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
                m_c[k] = m_c[k] | cy;
                m_v[k] = m_v[k] | ov;
                if (k == 1 && cy) m_out[k] = 32'hFFFF_FFFF;
                else              m_out[k] = us[31:0];
            end
        end
        e.out_w = m_out[0]; e.carry_w = m_c[0]; e.ovf_w = m_v[0];
        e.out_s = m_out[1]; e.carry_s = m_c[1]; e.ovf_s = m_v[1];
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [31:0] v);
        exp_t e;
        reset = r;
        in    = v;
        model_step(r, v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("wrap_out",   out_w,          e.out_w);
        check("wrap_carry", {31'd0, carry_w}, {31'd0, e.carry_w});
        check("wrap_ovf",   {31'd0, ovf_w},   {31'd0, e.ovf_w});
        check("sat_out",    out_s,          e.out_s);
        check("sat_carry",  {31'd0, carry_s}, {31'd0, e.carry_s});
        check("sat_ovf",    {31'd0, ovf_s},   {31'd0, e.ovf_s});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        in    = 32'd0;
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 32'd0; m_c[k] = 1'b0; m_v[k] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Reset state, then basic accumulation
        step(1'b0, 32'h0000_0000);
        check("reset_out_const", out_w, 32'h0000_0000);
        step(1'b1, 32'h0000_0001);
        step(1'b1, 32'h0000_0001);
        check("two_ones_const", out_w, 32'h0000_0002);
        step(1'b1, 32'h0000_00F0);
        check("f2_const", out_w, 32'h0000_00F2);

        // Reset wins over a nonzero input; first edge after reset loads in
        step(1'b0, 32'h0000_5400);
        step(1'b1, 32'hABCD_0000);
        check("reload_const", out_w, 32'hABCD_0000);

        // Unsigned wrap and carry, then hold with in = 0
        step(1'b0, 32'h0000_0000);
        step(1'b1, 32'hFFFF_FFFF);
        step(1'b1, 32'h0000_0002);
        check("wrap_const", out_w, 32'h0000_0001);
        check("sat_const",  out_s, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0000);

        // Exact carry onto 2^WIDTH gives zero in wrap mode
        step(1'b0, 32'h0000_0000);
        step(1'b1, 32'hFFFF_FFFF);
        step(1'b1, 32'h0000_0001);
        check("exact_wrap_const", out_w, 32'h0000_0000);

        // Signed overflow without carry
        step(1'b0, 32'h0000_0000);
        step(1'b1, 32'h7FFF_FFFF);
        step(1'b1, 32'h0000_0001);
        check("ovf_const", {31'd0, ovf_w}, 32'h0000_0001);

        // Negative-plus-negative signed overflow with carry
        step(1'b0, 32'h0000_0000);
        step(1'b1, 32'h8000_0000);
        step(1'b1, 32'h8000_0000);

        // Saturation holds at all-ones until reset
        step(1'b0, 32'h0000_0000);
        step(1'b1, 32'hFFFF_FFF0);
        step(1'b1, 32'h0000_0020);
        step(1'b1, 32'h0000_0005);
        check("sat_hold_const", out_s, 32'hFFFF_FFFF);
        step(1'b0, 32'h1234_5678);

        // Random traffic with occasional resets
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 19) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 32'h0000_0000 : 32'($urandom()));
        end

        if (exp_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
